// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant-lock arbitration stage.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int MAX_BEATS_DEFAULT = 8;

  // Index of the single set bit; returns 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational fixed-priority picker: one-hot of the lowest set request bit.
module prio_pick #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] pick
);

  logic found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grant_lock_arbiter.sv
// Registers the priority winner and holds the grant for a whole burst, releasing
// on last, on the beat limit, or when the owner drops its request.
module grant_lock_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         last,
  input  logic                     ready,
  output logic [WIDTH-1:0]         grant,
  output logic [$clog2(WIDTH)-1:0] owner,
  output logic                     busy,
  output logic                     beat,
  output logic                     forced,
  output logic                     abort
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

  arb_state_t       state, nxt_state;
  logic [CNT_W-1:0] beat_cnt, nxt_cnt;
  logic [WIDTH-1:0] pick, nxt_grant;
  logic [IDX_W-1:0] nxt_owner;
  logic             nxt_forced, nxt_abort;

  prio_pick #(.WIDTH(WIDTH)) u_pick (
    .req  (req),
    .pick (pick)
  );

  assign busy = (state == LOCK);
  assign beat = busy & req[owner] & ready;

  always_comb begin
    nxt_state  = state;
    nxt_grant  = grant;
    nxt_owner  = owner;
    nxt_cnt    = beat_cnt;
    nxt_forced = 1'b0;
    nxt_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          nxt_state = LOCK;
          nxt_grant = pick;
          nxt_owner = IDX_W'(onehot_to_idx(32'(pick)));
          nxt_cnt   = '0;
        end
      end
      LOCK: begin
        // Release priority: abandon, then last, then the beat limit.
        if (!req[owner]) begin
          nxt_state = IDLE;
          nxt_abort = 1'b1;
        end else if (beat && last[owner]) begin
          nxt_state = IDLE;
        end else if (beat && beat_cnt == CNT_LIMIT) begin
          nxt_state  = IDLE;
          nxt_forced = 1'b1;
        end else if (beat) begin
          nxt_cnt = beat_cnt + 1'b1;
        end
        if (nxt_state == IDLE) begin
          nxt_grant = '0;
          nxt_owner = '0;
          nxt_cnt   = '0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      forced   <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= nxt_state;
      grant    <= nxt_grant;
      owner    <= nxt_owner;
      beat_cnt <= nxt_cnt;
      forced   <= nxt_forced;
      abort    <= nxt_abort;
    end
  end

endmodule

// File: tb/tb_grant_lock_arbiter.sv
// Self-checking bench for grant_lock_arbiter: per-cycle vector table with a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_grant_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, last, grant;
  logic       ready;
  logic [1:0] owner;
  logic       busy, beat, forced, abort;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       beat;
    logic       forced;
    logic       abort;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  grant_lock_arbiter #(.WIDTH(4), .MAX_BEATS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .last   (last),
    .ready  (ready),
    .grant  (grant),
    .owner  (owner),
    .busy   (busy),
    .beat   (beat),
    .forced (forced),
    .abort  (abort)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    return '{grant: grant, owner: owner, busy: busy, beat: beat, forced: forced, abort: abort};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%b owner=%0d busy=%b beat=%b forced=%b abort=%b, want grant=%b owner=%0d busy=%b beat=%b forced=%b abort=%b",
                  name, act.grant, act.owner, act.busy, act.beat, act.forced, act.abort,
                  exp.grant, exp.owner, exp.busy, exp.beat, exp.forced, exp.abort);
  endtask

  function automatic exp_t e(input logic [3:0] g, input logic [1:0] o, input logic bz,
                             input logic bt, input logic f, input logic a);
    return '{grant: g, owner: o, busy: bz, beat: bt, forced: f, abort: a};
  endfunction

  // One table row: inputs held for one cycle, outputs expected in that cycle.
  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic rd, input exp_t x);
    vec_t v;
    v.req = r; v.last = l; v.ready = rd; v.exp = x;
    vecs.push_back(v);
  endtask

  localparam exp_t IDLE_E = '0;

  initial begin
    // Priority, backpressure and abort.
    add(4'b1110, 4'b0000, 1'b0, IDLE_E);
    add(4'b1111, 4'b0000, 1'b0, e(4'b0010, 2'd1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      add(4'b1111, 4'b0000, 1'b0, e(4'b0010, 2'd1, 1, 0, 0, 0));
    add(4'b1101, 4'b0000, 1'b1, e(4'b0010, 2'd1, 1, 0, 0, 0));
    add(4'b0000, 4'b0000, 1'b1, e(4'b0000, 2'd0, 0, 0, 0, 1));
    add(4'b0000, 4'b0000, 1'b1, IDLE_E);
    // Normal burst: owner 2, last on the third beat, dead cycle, re-grant.
    add(4'b0100, 4'b0000, 1'b1, IDLE_E);
    add(4'b0100, 4'b0000, 1'b1, e(4'b0100, 2'd2, 1, 1, 0, 0));
    add(4'b0100, 4'b0000, 1'b1, e(4'b0100, 2'd2, 1, 1, 0, 0));
    add(4'b0100, 4'b0100, 1'b1, e(4'b0100, 2'd2, 1, 1, 0, 0));
    add(4'b0100, 4'b0000, 1'b0, IDLE_E);
    add(4'b0100, 4'b0000, 1'b0, e(4'b0100, 2'd2, 1, 0, 0, 0));
    add(4'b0000, 4'b0000, 1'b0, e(4'b0100, 2'd2, 1, 0, 0, 0));
    add(4'b0000, 4'b0000, 1'b0, e(4'b0000, 2'd0, 0, 0, 0, 1));
    // Forced release after eight beats, then eight beats with last on the eighth.
    add(4'b0001, 4'b0000, 1'b1, IDLE_E);
    for (int i = 0; i < 8; i++)
      add(4'b0001, 4'b0000, 1'b1, e(4'b0001, 2'd0, 1, 1, 0, 0));
    add(4'b0001, 4'b0000, 1'b1, e(4'b0000, 2'd0, 0, 0, 1, 0));
    for (int i = 0; i < 7; i++)
      add(4'b0001, 4'b0000, 1'b1, e(4'b0001, 2'd0, 1, 1, 0, 0));
    add(4'b0001, 4'b0001, 1'b1, e(4'b0001, 2'd0, 1, 1, 0, 0));
    add(4'b0000, 4'b0000, 1'b1, IDLE_E);
    add(4'b0000, 4'b0000, 1'b0, IDLE_E);

    // Reset with all requests high.
    rst = 1'b1; req = 4'b1111; last = 4'b0000; ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check("reset", actual(), IDLE_E);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      req = vecs[i].req; last = vecs[i].last; ready = vecs[i].ready;
      sb.push_back(vecs[i].exp);
      #2;
      if (sb.size() == 0) check($sformatf("vec%0d_empty", i), actual(), IDLE_E);
      else check($sformatf("vec%0d", i), actual(), sb.pop_front());
    end

    // Asynchronous reset while locked: grant drops between edges, no pulses.
    @(negedge clk);
    req = 4'b0001; ready = 1'b0; last = 4'b0000;
    @(negedge clk);
    #1 check("lock_before_rst", actual(), e(4'b0001, 2'd0, 1, 0, 0, 0));
    #1 rst = 1'b1;
    #1 check("async_rst_mid", actual(), IDLE_E);
    @(negedge clk);
    #1 check("rst_no_pulse", actual(), IDLE_E);
    req = 4'b0000; rst = 1'b0;
    @(negedge clk);
    #1 check("post_rst_idle", actual(), IDLE_E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

endmodule
